// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - receive-side holding register handshake bundle
//
// Carries one received word plus its error flags from the receive engine
// toward the consumer (bus-side FIFO or register block).
//   rx_data    : received data word, LSB first on the line
//   rx_valid   : rx_data / parity_err / frame_err valid, held until accepted
//   rx_ready   : consumer accepts when rx_valid && rx_ready
//   parity_err : parity mismatch for the word in rx_data
//   frame_err  : a stop bit was sampled low for the word in rx_data
// master = receive engine, slave = consumer.
interface uart_rx_os_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 parity_err;
   logic                 frame_err;

   modport master (
      output rx_data,
      output rx_valid,
      output parity_err,
      output frame_err,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  parity_err,
      input  frame_err,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receive engine with holding register
//
// Recovers asynchronous frames (start, DATA_BITS data LSB first, optional
// parity, STOP_BITS stop) from an OVERSAMPLE x baud clock with mid-bit
// sampling and false-start rejection.
// Optional feature macro: UART_RX_MAJORITY_EN - every bit decision is the
// 2-of-3 majority of the synchronized input over the decision cycle and the
// two cycles before it. Without it the single synchronized value is used.
// Ports:
//   baud_clk    : OVERSAMPLE x baud clock, rising edge
//   reset       : synchronous active-high reset
//   data_rx     : asynchronous serial input, idle high
//   rx_if       : holding register handshake (master side)
//   overrun_err : one-cycle pulse when a completed frame is dropped
//   active_flag : high from start detection until return to idle
module uart_rx_os #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic          baud_clk,
   input  logic          reset,
   input  logic          data_rx,
   uart_rx_os_if.master  rx_if,
   output logic          overrun_err,
   output logic          active_flag
);
   localparam int SCW = $clog2(OVERSAMPLE);
   localparam int BCW = 4;
   localparam logic [SCW-1:0] SCNT_MID  = SCW'(OVERSAMPLE/2 - 1);
   localparam logic [SCW-1:0] SCNT_LAST = SCW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q;
   logic [SCW-1:0]       scnt_q, scnt_d;
   logic [BCW-1:0]       bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 ppar_q, ppar_d;
   logic                 pfrm_q, pfrm_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 active_q, active_d;
   logic                 rxs;
   logic                 bit_s;
   logic                 done;
   logic                 done_ferr;

   assign rxs = sync2_q;

`ifdef UART_RX_MAJORITY_EN
   logic hist1_q, hist2_q;
   assign bit_s = (rxs & hist1_q) | (rxs & hist2_q) | (hist1_q & hist2_q);

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         hist1_q <= 1'b1;
         hist2_q <= 1'b1;
      end else begin
         hist1_q <= rxs;
         hist2_q <= hist1_q;
      end
   end
`else
   assign bit_s = rxs;
`endif

   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q + 1'b1;
      bcnt_d    = bcnt_q;
      shreg_d   = shreg_q;
      ppar_d    = ppar_q;
      pfrm_d    = pfrm_q;
      active_d  = active_q;
      done      = 1'b0;
      done_ferr = 1'b0;
      case (state_q)
         S_IDLE: begin
            scnt_d = '0;
            if (!rxs) begin
               state_d  = S_START;
               active_d = 1'b1;
            end
         end
         S_START: begin
            if (scnt_q == SCNT_MID) begin
               if (bit_s) begin
                  state_d  = S_IDLE;
                  active_d = 1'b0;
               end else begin
                  // Re-phase the counter so later samples land mid-bit.
                  state_d = S_DATA;
                  scnt_d  = '0;
                  bcnt_d  = '0;
                  ppar_d  = 1'b0;
                  pfrm_d  = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (scnt_q == SCNT_LAST) begin
               shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
               if (bcnt_q == BCW'(DATA_BITS - 1)) begin
                  bcnt_d  = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (scnt_q == SCNT_LAST) begin
               ppar_d  = ((^shreg_q) ^ bit_s) != PARITY_ODD[0];
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (scnt_q == SCNT_LAST) begin
               if (!bit_s) begin
                  pfrm_d = 1'b1;
               end
               // Leave at mid stop bit so a following start edge is caught.
               if (bcnt_q == BCW'(STOP_BITS - 1)) begin
                  state_d   = S_IDLE;
                  active_d  = 1'b0;
                  done      = 1'b1;
                  done_ferr = pfrm_q | ~bit_s;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d  = S_IDLE;
            active_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = 1'b0;
      if (done) begin
         if (!valid_q || rx_if.rx_ready) begin
            data_d  = shreg_q;
            perr_d  = ppar_q;
            ferr_d  = done_ferr;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_if.rx_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= S_IDLE;
         scnt_q   <= '0;
         bcnt_q   <= '0;
         shreg_q  <= '0;
         ppar_q   <= 1'b0;
         pfrm_q   <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         sync1_q  <= data_rx;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         scnt_q   <= scnt_d;
         bcnt_q   <= bcnt_d;
         shreg_q  <= shreg_d;
         ppar_q   <= ppar_d;
         pfrm_q   <= pfrm_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
         active_q <= active_d;
      end
   end

   assign rx_if.rx_data    = data_q;
   assign rx_if.rx_valid   = valid_q;
   assign rx_if.parity_err = perr_q;
   assign rx_if.frame_err  = ferr_q;
   assign overrun_err      = ovr_q;
   assign active_flag      = active_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os
module tb_uart_rx_os;
   logic baud_clk = 1'b0;
   logic reset    = 1'b1;
   logic data_rx  = 1'b1;
   logic overrun_err;
   logic active_flag;

   uart_rx_os_if #(.DATA_BITS(8)) rx_if ();

   uart_rx_os dut (
      .baud_clk    (baud_clk),
      .reset       (reset),
      .data_rx     (data_rx),
      .rx_if       (rx_if),
      .overrun_err (overrun_err),
      .active_flag (active_flag)
   );

   always #5 baud_clk = ~baud_clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int start_cyc;
   int rise_cyc = -1;
   int vcnt     = 0;
   int ocnt     = 0;
   logic prev_valid = 1'b0;
   logic [7:0] cap_data[$];
   logic       cap_perr[$];
   logic       cap_ferr[$];

   always @(posedge baud_clk) cyc <= cyc + 1;

   // Observer: samples on the falling edge, away from the active edge.
   always @(negedge baud_clk) begin
      if (rx_if.rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_if.rx_valid;
      if (rx_if.rx_valid) vcnt++;
      if (overrun_err) ocnt++;
      if (rx_if.rx_valid && rx_if.rx_ready) begin
         cap_data.push_back(rx_if.rx_data);
         cap_perr.push_back(rx_if.parity_err);
         cap_ferr.push_back(rx_if.frame_err);
      end
   end

   task automatic clear_obs();
      cap_data.delete();
      cap_perr.delete();
      cap_ferr.delete();
      vcnt     = 0;
      ocnt     = 0;
      rise_cyc = -1;
   endtask

   task automatic idle(input int n);
      data_rx = 1'b1;
      repeat (n) @(posedge baud_clk);
      #1;
   endtask

   // start, 8 data LSB first, even parity (optionally flipped), one stop
   task automatic send_frame(input logic [7:0] d, input logic par_flip,
                             input logic stop_val, input int glitch_c);
      logic [10:0] fb;
      fb = {stop_val, (^d) ^ par_flip, d, 1'b0};
      start_cyc = cyc;
      for (int c = 0; c < 176; c++) begin
         data_rx = fb[c/16];
         if (c == glitch_c) data_rx = 1'b1;
         @(posedge baud_clk);
         #1;
      end
      data_rx = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx_if.rx_ready = 1'b1;
      repeat (3) @(posedge baud_clk);
      #1;
      checks++; if (rx_if.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_if.rx_valid); end
      checks++; if (rx_if.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data); end
      checks++; if ({rx_if.parity_err, rx_if.frame_err, overrun_err, active_flag} !== 4'b0000) begin
         failures++; $display("FAIL reset_flags got=%b exp=0000", {rx_if.parity_err, rx_if.frame_err, overrun_err, active_flag}); end
      reset = 1'b0;
      idle(20);
   endtask

   task automatic test_basic();
      clear_obs();
      send_frame(8'h5A, 1'b0, 1'b1, -1);
      idle(4);
      checks++; if (rise_cyc - start_cyc !== 171) begin failures++; $display("FAIL basic_latency got=%0d exp=171", rise_cyc - start_cyc); end
      checks++; if (vcnt !== 1) begin failures++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcnt); end
      checks++; if (cap_data.size() !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", cap_data.size()); end
      else begin
         checks++; if ({cap_data[0], cap_perr[0], cap_ferr[0]} !== {8'h5A, 2'b00}) begin
            failures++; $display("FAIL basic_word got=%h/%b/%b exp=5a/0/0", cap_data[0], cap_perr[0], cap_ferr[0]); end
      end
   endtask

   task automatic test_errors();
      clear_obs();
      send_frame(8'h5A, 1'b1, 1'b1, -1);
      idle(8);
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      idle(40);
      send_frame(8'hA5, 1'b0, 1'b1, -1);
      idle(8);
      checks++; if (cap_data.size() !== 3) begin failures++; $display("FAIL err_count got=%0d exp=3", cap_data.size()); end
      else begin
         checks++; if ({cap_data[0], cap_perr[0], cap_ferr[0]} !== {8'h5A, 2'b10}) begin
            failures++; $display("FAIL parity_err got=%h/%b/%b exp=5a/1/0", cap_data[0], cap_perr[0], cap_ferr[0]); end
         checks++; if ({cap_data[1], cap_perr[1], cap_ferr[1]} !== {8'h3C, 2'b01}) begin
            failures++; $display("FAIL frame_err got=%h/%b/%b exp=3c/0/1", cap_data[1], cap_perr[1], cap_ferr[1]); end
         checks++; if ({cap_data[2], cap_perr[2], cap_ferr[2]} !== {8'hA5, 2'b00}) begin
            failures++; $display("FAIL recovery got=%h/%b/%b exp=a5/0/0", cap_data[2], cap_perr[2], cap_ferr[2]); end
      end
   endtask

   task automatic test_false_start();
      clear_obs();
      data_rx = 1'b0;
      repeat (4) @(posedge baud_clk);
      #1;
      data_rx = 1'b1;
      checks++; if (active_flag !== 1'b1) begin failures++; $display("FAIL false_start_active got=%b exp=1", active_flag); end
      idle(30);
      checks++; if (active_flag !== 1'b0) begin failures++; $display("FAIL false_start_idle got=%b exp=0", active_flag); end
      checks++; if (vcnt !== 0) begin failures++; $display("FAIL false_start_valid got=%0d exp=0", vcnt); end
   endtask

   task automatic test_back_to_back();
      clear_obs();
      send_frame(8'h66, 1'b0, 1'b1, -1);
      send_frame(8'h99, 1'b0, 1'b1, -1);
      idle(4);
      checks++; if (cap_data.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", cap_data.size()); end
      else begin
         checks++; if ({cap_data[0], cap_data[1]} !== 16'h6699) begin
            failures++; $display("FAIL b2b_data got=%h%h exp=6699", cap_data[0], cap_data[1]); end
      end
   endtask

   task automatic test_overrun();
      clear_obs();
      rx_if.rx_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, -1);
      send_frame(8'h22, 1'b0, 1'b1, -1);
      idle(4);
      checks++; if ({rx_if.rx_valid, rx_if.rx_data} !== {1'b1, 8'h11}) begin
         failures++; $display("FAIL overrun_hold got=%b/%h exp=1/11", rx_if.rx_valid, rx_if.rx_data); end
      checks++; if (ocnt !== 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", ocnt); end
      rx_if.rx_ready = 1'b1;
      @(posedge baud_clk);
      #1;
      checks++; if (rx_if.rx_valid !== 1'b0) begin failures++; $display("FAIL accept_drop got=%b exp=0", rx_if.rx_valid); end
      checks++; if (cap_data.size() !== 1 || cap_data[0] !== 8'h11) begin
         failures++; $display("FAIL accept_data got_n=%0d exp=1 word 11", cap_data.size()); end
   endtask

   task automatic test_reset_mid_frame();
      clear_obs();
      data_rx = 1'b0;
      repeat (16) @(posedge baud_clk);
      #1;
      data_rx = 1'b1;
      repeat (24) @(posedge baud_clk);
      #1;
      reset = 1'b1;
      repeat (3) @(posedge baud_clk);
      #1;
      checks++; if ({rx_if.rx_valid, rx_if.rx_data, rx_if.parity_err, rx_if.frame_err, overrun_err, active_flag} !== 13'h0) begin
         failures++; $display("FAIL midreset_outputs got=%b/%h/%b exp=0/00/0000", rx_if.rx_valid, rx_if.rx_data,
                              {rx_if.parity_err, rx_if.frame_err, overrun_err, active_flag}); end
      reset = 1'b0;
      idle(40);
      send_frame(8'h44, 1'b0, 1'b1, -1);
      idle(4);
      checks++; if (cap_data.size() !== 1 || cap_data[0] !== 8'h44) begin
         failures++; $display("FAIL midreset_next got_n=%0d exp=1 word 44", cap_data.size()); end
   endtask

   task automatic test_glitch();
      logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
      exp_d = 8'h00;
`else
      exp_d = 8'h01;
`endif
      clear_obs();
      // data_rx high only across the edge that feeds the data bit 0 decision
      send_frame(8'h00, 1'b0, 1'b1, 24);
      idle(4);
      checks++; if (cap_data.size() !== 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", cap_data.size()); end
      else begin
         checks++; if (cap_data[0] !== exp_d) begin failures++; $display("FAIL glitch_data got=%h exp=%h", cap_data[0], exp_d); end
      end
   endtask

   initial begin
      rx_if.rx_ready = 1'b1;
      test_reset();
      test_basic();
      test_errors();
      test_false_start();
      test_back_to_back();
      test_overrun();
      test_reset_mid_frame();
      test_glitch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
